// File: rtl/gray_pkg.sv
// Shared definitions for the Gray/binary converter.
//   state_e   : converter FSM states (IDLE, BUSY, DONE)
//   MODE_G2B  : mode value selecting Gray-to-binary
//   MODE_B2G  : mode value selecting binary-to-Gray
//   cnt_width : width of the step counter, clog2(width/step), at least 1 bit
package gray_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic MODE_G2B = 1'b0;
  localparam logic MODE_B2G = 1'b1;

  function automatic int unsigned cnt_width(input int unsigned width, input int unsigned step);
    int unsigned n;
    int unsigned w;
    n = width / step;
    // A single-step conversion still needs a 1-bit counter to have a legal vector.
    for (w = 1; (64'd1 << w) < 64'(n); w++) begin
    end
    return w;
  endfunction

endpackage

// File: rtl/gray_step_slice.sv
// One STEP-bit slice of a Gray-to-binary conversion, resolved MSB-first.
//   carry_i : binary bit directly above this slice (0 for the top slice)
//   gray_i  : Gray-coded slice
//   bin_o   : binary slice, bin[i] = bin[i+1] ^ gray[i]
// Purely combinational.
module gray_step_slice #(
  parameter int unsigned STEP = 1
) (
  input  logic            carry_i,
  input  logic [STEP-1:0] gray_i,
  output logic [STEP-1:0] bin_o
);

  always_comb begin
    logic c;
    bin_o = '0;
    c     = carry_i;
    // Running XOR kept in a scalar to avoid a self-referencing vector.
    for (int i = int'(STEP) - 1; i >= 0; i--) begin
      c        = c ^ gray_i[i];
      bin_o[i] = c;
    end
  end

endmodule

// File: rtl/gray_binary_converter.sv
// Multi-cycle Gray <-> binary converter with valid/ready handshakes on both sides.
//   clk, rst            : clock and asynchronous active-high reset
//   in_valid/in_ready   : input handshake (ready only in IDLE)
//   mode                : 0 = Gray-to-binary, 1 = binary-to-Gray, sampled with in_data
//   in_data             : word to convert
//   out_valid/out_ready : output handshake (valid only in DONE)
//   out_data            : converted word, held until the next result
//   busy                : high in BUSY or DONE
//   out_parity          : XOR-reduction of out_data, only with GRAY_CONV_PARITY_EN defined
// Binary-to-Gray takes one BUSY cycle; Gray-to-binary takes WIDTH/STEP BUSY cycles.
module gray_binary_converter
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned STEP  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             mode,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
`ifdef GRAY_CONV_PARITY_EN
  ,
  output logic             out_parity
`endif
);

  localparam int unsigned NumSteps = WIDTH / STEP;
  localparam int unsigned CntW     = cnt_width(WIDTH, STEP);
  localparam logic [CntW-1:0] LastCnt = CntW'(NumSteps - 1);

  state_e            state_q, state_d;
  logic              mode_q, mode_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]  data_q, data_d;  // Gray input, shifted left one slice per step
  logic [WIDTH-1:0]  acc_q, acc_d;    // binary bits resolved so far, LSB = last bit
  logic [WIDTH-1:0]  res_q, res_d;
  logic [STEP-1:0]   slice_bin;

  // The top slice of data_q is always the next one to resolve; its carry is the
  // most recently resolved bit, which sits at acc_q[0] (zero for the first slice).
  gray_step_slice #(
    .STEP(STEP)
  ) u_slice (
    .carry_i(acc_q[0]),
    .gray_i (data_q[WIDTH-1 -: STEP]),
    .bin_o  (slice_bin)
  );

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    acc_d   = acc_q;
    res_d   = res_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          mode_d  = mode;
          data_d  = in_data;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (mode_q == MODE_B2G) begin
          res_d   = data_q ^ (data_q >> 1);
          state_d = DONE;
        end else begin
          data_d = data_q << STEP;
          acc_d  = (acc_q << STEP) | WIDTH'(slice_bin);
          cnt_d  = cnt_q + CntW'(1);
          if (cnt_q == LastCnt) begin
            res_d   = acc_d;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q  <= MODE_G2B;
      cnt_q   <= '0;
      data_q  <= '0;
      acc_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
    end
  end

`ifdef GRAY_CONV_PARITY_EN
  logic par_q;

  // res_d equals res_q outside a completing edge, so parity always tracks out_data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_q <= 1'b0;
    end else begin
      par_q <= ^res_d;
    end
  end

  assign out_parity = par_q;
`endif

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_data  = res_q;

endmodule
